// File: rtl/aes_reg_bank_if.sv
// Bus bundle for aes_reg_bank: software register port plus AES core handshake.
// master = software/core side, slave = the register bank.
interface aes_reg_bank_if #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 4
);
    logic                  WE;
    logic                  RE;
    logic [ADDR_W-1:0]     ADDR;
    logic [DATA_W/8-1:0]   BE;
    logic [DATA_W-1:0]     WDATA;
    logic [DATA_W-1:0]     RDATA;
    logic                  RVALID;
    logic                  HW_DONE;
    logic [4*DATA_W-1:0]   HW_DEC;
    logic [4*DATA_W-1:0]   AES_KEY;
    logic [4*DATA_W-1:0]   AES_MSG_EN;
    logic                  START_PULSE;
    logic                  BUSY;
    logic                  IRQ;

    modport master (
        output WE, RE, ADDR, BE, WDATA, HW_DONE, HW_DEC,
        input  RDATA, RVALID, AES_KEY, AES_MSG_EN, START_PULSE, BUSY, IRQ
    );

    modport slave (
        input  WE, RE, ADDR, BE, WDATA, HW_DONE, HW_DEC,
        output RDATA, RVALID, AES_KEY, AES_MSG_EN, START_PULSE, BUSY, IRQ
    );
endinterface

// File: rtl/aes_reg_bank.sv
// AES register bank: key/message/result registers, START/DONE handshake, registered reads.
// Optional completion interrupt compiled in with `define AES_REG_IRQ_EN.
module aes_reg_bank #(
    parameter int DATA_W   = 32,
    parameter int NUM_REGS = 16,
    parameter int ADDR_W   = $clog2(NUM_REGS)
) (
    input logic           Clk,
    input logic           Reset,
    aes_reg_bank_if.slave bus
);
    localparam int NB       = DATA_W / 8;
    localparam int NPLAIN   = NUM_REGS - 2;
    localparam int CTRL_IDX = 12;
    localparam logic [ADDR_W:0]   NUM_REGS_W = (ADDR_W+1)'(NUM_REGS);
    localparam logic [ADDR_W-1:0] START_A    = ADDR_W'(NUM_REGS - 2);
    localparam logic [ADDR_W-1:0] DONE_A     = ADDR_W'(NUM_REGS - 1);

    logic [DATA_W-1:0] regs [NPLAIN];
    logic [DATA_W-1:0] dec_word [4];
    logic              busy, done, start_pulse, irq;
    logic              sw_wr, start_req, done_clr;
    logic [DATA_W-1:0] rd_val;
    logic [DATA_W-1:0] rdata_p1;
    logic              vld_p1;

    for (genvar j = 0; j < 4; j++) begin : g_dec
        assign dec_word[j] = bus.HW_DEC[j*DATA_W +: DATA_W];
    end

    assign sw_wr     = bus.WE && ({1'b0, bus.ADDR} < NUM_REGS_W);
    assign start_req = sw_wr && (bus.ADDR == START_A) && bus.BE[0] && bus.WDATA[0];
    assign done_clr  = sw_wr && (bus.ADDR == DONE_A) && bus.BE[0] && bus.WDATA[0];

    // Data registers; HW_DONE result load wins over a software write to regs 8-11.
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            for (int i = 0; i < NPLAIN; i++) regs[i] <= '0;
        end else begin
            for (int i = 0; i < NPLAIN; i++) begin
                if (bus.HW_DONE && i >= 8 && i <= 11) begin
                    regs[i] <= dec_word[2'(i - 8)];
                end else if (sw_wr && bus.ADDR == ADDR_W'(i)) begin
                    for (int b = 0; b < NB; b++) begin
                        if (bus.BE[b]) regs[i][b*8 +: 8] <= bus.WDATA[b*8 +: 8];
                    end
                end
            end
        end
    end

    // START/DONE control bits; a start request while busy is dropped.
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            busy        <= 1'b0;
            done        <= 1'b0;
            start_pulse <= 1'b0;
        end else begin
            start_pulse <= 1'b0;
            if (bus.HW_DONE) begin
                busy <= 1'b0;
                done <= 1'b1;
            end else begin
                if (start_req && !busy) begin
                    busy        <= 1'b1;
                    start_pulse <= 1'b1;
                end
                if (done_clr) done <= 1'b0;
            end
        end
    end

`ifdef AES_REG_IRQ_EN
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) irq <= 1'b0;
        else       irq <= done & regs[CTRL_IDX][0];
    end
`else
    assign irq = 1'b0;
`endif

    always_comb begin
        rd_val = '0;
        if (bus.ADDR == START_A) begin
            rd_val = {{(DATA_W-1){1'b0}}, busy};
        end else if (bus.ADDR == DONE_A) begin
            rd_val = {{(DATA_W-1){1'b0}}, done};
        end else begin
            for (int i = 0; i < NPLAIN; i++) begin
                if (bus.ADDR == ADDR_W'(i)) rd_val = regs[i];
            end
        end
    end

    // Stage p1: read data captured from pre-edge state; holds while no read.
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            rdata_p1 <= '0;
            vld_p1   <= 1'b0;
        end else begin
            vld_p1 <= bus.RE;
            if (bus.RE) rdata_p1 <= rd_val;
        end
    end

    assign bus.RDATA       = rdata_p1;
    assign bus.RVALID      = vld_p1;
    assign bus.AES_KEY     = {regs[3], regs[2], regs[1], regs[0]};
    assign bus.AES_MSG_EN  = {regs[7], regs[6], regs[5], regs[4]};
    assign bus.START_PULSE = start_pulse;
    assign bus.BUSY        = busy;
    assign bus.IRQ         = irq;
endmodule

// File: tb/tb_aes_reg_bank.sv
// Scoreboard bench for aes_reg_bank: reads push expected data, a negedge monitor pops on RVALID.
module tb_aes_reg_bank;
    localparam int DATA_W   = 32;
    localparam int NUM_REGS = 32;
    localparam int ADDR_W   = 6;
`ifdef AES_REG_IRQ_EN
    localparam logic IRQ_ON = 1'b1;
`else
    localparam logic IRQ_ON = 1'b0;
`endif
    localparam logic [127:0] DEC1 = 128'h00112233_44556677_01234567_89ABCDEF;
    localparam logic [127:0] DEC2 = 128'hA0A1A2A3_B0B1B2B3_C0C1C2C3_D0D1D2D3;

    logic Clk = 1'b0;
    logic Reset = 1'b1;
    always #5 Clk = ~Clk;

    aes_reg_bank_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) bus ();

    aes_reg_bank #(.DATA_W(DATA_W), .NUM_REGS(NUM_REGS), .ADDR_W(ADDR_W)) dut (
        .Clk   (Clk),
        .Reset (Reset),
        .bus   (bus)
    );

    int n_tests = 0;
    int n_fail  = 0;
    logic [31:0] exp_q  [$];
    int          addr_q [$];

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Monitor: every RVALID must match the oldest outstanding read.
    always @(negedge Clk) begin
        if (bus.RVALID === 1'b1) begin
            if (exp_q.size() == 0) begin
                n_tests++;
                n_fail++;
                $display("FAIL unexpected_rvalid: got RDATA %0h expected no read", bus.RDATA);
            end else begin
                check($sformatf("rdata_addr%0d", addr_q.pop_front()), bus.RDATA, exp_q.pop_front());
            end
        end
    end

    task automatic cyc();
        @(posedge Clk);
        #1;
        bus.WE = 1'b0;
        bus.RE = 1'b0;
        bus.HW_DONE = 1'b0;
    endtask

    task automatic set_wr(input int a, input logic [3:0] be, input logic [31:0] d);
        bus.WE = 1'b1;
        bus.ADDR = ADDR_W'(a);
        bus.BE = be;
        bus.WDATA = d;
    endtask

    task automatic set_rd(input int a, input logic [31:0] e);
        bus.RE = 1'b1;
        bus.ADDR = ADDR_W'(a);
        exp_q.push_back(e);
        addr_q.push_back(a);
    endtask

    task automatic wr(input int a, input logic [3:0] be, input logic [31:0] d);
        set_wr(a, be, d);
        cyc();
    endtask

    task automatic rd(input int a, input logic [31:0] e);
        set_rd(a, e);
        cyc();
    endtask

    initial begin
        bus.WE = 1'b0; bus.RE = 1'b0; bus.ADDR = '0; bus.BE = '0; bus.WDATA = '0;
        bus.HW_DONE = 1'b0; bus.HW_DEC = '0;
        repeat (2) @(posedge Clk);
        #1;
        check("reset_rdata", bus.RDATA, 0);
        check("reset_rvalid", bus.RVALID, 0);
        check("reset_busy", bus.BUSY, 0);
        check("reset_start_pulse", bus.START_PULSE, 0);
        check("reset_irq", bus.IRQ, 0);
        check("reset_key", bus.AES_KEY, 0);
        Reset = 1'b0;

        // Byte-enable writes and registered reads
        wr(2, 4'b0101, 32'hDEADBEEF);
        check("key_word2", bus.AES_KEY[95:64], 32'h00AD00EF);
        rd(2, 32'h00AD00EF);
        check("rvalid_pulse", bus.RVALID, 1);
        cyc();
        check("rvalid_drop", bus.RVALID, 0);
        check("rdata_hold", bus.RDATA, 32'h00AD00EF);
        wr(2, 4'b1010, 32'h11223344);
        rd(2, 32'h11AD33EF);
        wr(5, 4'hF, 32'hCAFEF00D);
        check("msg_word1", bus.AES_MSG_EN[63:32], 32'hCAFEF00D);

        // Read-before-write, out-of-range access, plain registers
        wr(0, 4'hF, 32'hA5A5A5A5);
        set_wr(0, 4'hF, 32'h12345678);
        set_rd(0, 32'hA5A5A5A5);
        cyc();
        rd(0, 32'h12345678);
        rd(32, 32'h0);
        rd(63, 32'h0);
        wr(45, 4'hF, 32'hFFFFFFFF);
        rd(13, 32'h0);
        wr(20, 4'hF, 32'h13572468);
        rd(20, 32'h13572468);

        // START handshake
        wr(30, 4'h1, 32'h1);
        check("start_pulse_on", bus.START_PULSE, 1);
        check("busy_set", bus.BUSY, 1);
        cyc();
        check("start_pulse_off", bus.START_PULSE, 0);
        wr(30, 4'h1, 32'h1);
        check("restart_no_pulse", bus.START_PULSE, 0);
        cyc();
        check("restart_no_pulse2", bus.START_PULSE, 0);
        wr(30, 4'h1, 32'h0);
        check("start_write0_keeps", bus.BUSY, 1);
        wr(30, 4'hF, 32'hFFFFFFFF);
        rd(30, 32'h1);

        // HW_DONE beats a same-cycle write to reg9
        bus.HW_DEC = DEC1;
        bus.HW_DONE = 1'b1;
        set_wr(9, 4'hF, 32'h5);
        cyc();
        check("done_busy_clr", bus.BUSY, 0);
        check("done_no_pulse", bus.START_PULSE, 0);
        rd(8, 32'h89ABCDEF);
        rd(9, 32'h01234567);
        rd(10, 32'h44556677);
        rd(11, 32'h00112233);
        rd(31, 32'h1);
        rd(30, 32'h0);

        // HW_DONE beats a same-cycle DONE clear; also arrives with BUSY=0
        bus.HW_DEC = DEC2;
        bus.HW_DONE = 1'b1;
        set_wr(31, 4'h1, 32'h1);
        cyc();
        check("idle_done_no_pulse", bus.START_PULSE, 0);
        rd(31, 32'h1);
        rd(8, 32'hD0D1D2D3);
        wr(31, 4'hE, 32'hFFFFFFFF);
        rd(31, 32'h1);
        wr(31, 4'h1, 32'h1);
        rd(31, 32'h0);

        // HW_DONE beats a same-cycle START write
        bus.HW_DONE = 1'b1;
        set_wr(30, 4'h1, 32'h1);
        cyc();
        check("start_vs_done_busy", bus.BUSY, 0);
        check("start_vs_done_pulse", bus.START_PULSE, 0);
        wr(31, 4'h1, 32'h1);

        // Interrupt path (tied low when the feature is compiled out)
        wr(12, 4'h1, 32'h1);
        rd(12, 32'h1);
        bus.HW_DONE = 1'b1;
        cyc();
        check("irq_lags_done", bus.IRQ, 0);
        cyc();
        check("irq_after_done", bus.IRQ, IRQ_ON);
        wr(31, 4'h1, 32'h1);
        check("irq_w1c_edge", bus.IRQ, IRQ_ON);
        cyc();
        check("irq_cleared", bus.IRQ, 0);

        // Reset in the middle of a read while busy
        wr(0, 4'hF, 32'h77777777);
        wr(30, 4'h1, 32'h1);
        check("busy_before_reset", bus.BUSY, 1);
        bus.RE = 1'b1;
        bus.ADDR = ADDR_W'(0);
        @(negedge Clk);
        Reset = 1'b1;
        #1;
        check("rst_busy", bus.BUSY, 0);
        check("rst_rdata", bus.RDATA, 0);
        check("rst_rvalid", bus.RVALID, 0);
        check("rst_key", bus.AES_KEY, 0);
        check("rst_start_pulse", bus.START_PULSE, 0);
        check("rst_irq", bus.IRQ, 0);
        @(posedge Clk);
        #1;
        bus.RE = 1'b0;
        check("rst_rvalid_held", bus.RVALID, 0);
        @(posedge Clk);
        #1;
        Reset = 1'b0;
        cyc();
        check("post_rst_rvalid", bus.RVALID, 0);

        // Completion after reset is handled as an idle completion
        bus.HW_DEC = DEC1;
        bus.HW_DONE = 1'b1;
        cyc();
        check("post_rst_no_pulse", bus.START_PULSE, 0);
        check("post_rst_busy", bus.BUSY, 0);
        rd(31, 32'h1);
        rd(8, 32'h89ABCDEF);
        rd(0, 32'h0);
        rd(20, 32'h0);

        repeat (3) cyc();
        check("reads_outstanding", exp_q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/aes_reg_bank.md
AES_REG_BANK -- requirements
Module: aes_reg_bank

Interface
REQ-001 SHALL have parameter DATA_W, default 32, register width in bits; legal values are multiples of 8, at least 32.
REQ-002 SHALL have parameter NUM_REGS, default 16, register count; legal values are at least 16.
REQ-003 SHALL have parameter ADDR_W, default $clog2(NUM_REGS), address width.
REQ-004 SHALL use one clock and an asynchronous, active-high reset, with these ports:
- Clk  in  1  single clock; all state updates on the rising edge.
- Reset  in  1  asynchronous, active-high reset.
- WE  in  1  software write strobe.
- RE  in  1  software read strobe.
- ADDR  in  ADDR_W  software register index.
- BE  in  DATA_W/8  byte enables for writes.
- WDATA  in  DATA_W  software write data.
- RDATA  out  DATA_W  registered read data.
- RVALID  out  1  one-cycle pulse marking RDATA valid.
- HW_DONE  in  1  one-cycle completion pulse from the AES core.
- HW_DEC  in  4*DATA_W  decrypted result from the AES core.
- AES_KEY  out  4*DATA_W  {reg3,reg2,reg1,reg0}.
- AES_MSG_EN  out  4*DATA_W  {reg7,reg6,reg5,reg4}.
- START_PULSE  out  1  one-cycle pulse when the core is started.
- BUSY  out  1  START register bit 0.
- IRQ  out  1  completion interrupt.

Function
REQ-005 SHALL fix the register map as follows; regs 13 to NUM_REGS-3 are plain general-purpose registers.
- 0-3: key.
- 4-7: message in.
- 8-11: decrypted message.
- 12: control (CTRL).
- NUM_REGS-2: START.
- NUM_REGS-1: DONE.
REQ-006 SHALL, on WE with ADDR<NUM_REGS, update only bytes whose BE bit is 1 at the next edge (plain registers); WE with ADDR>=NUM_REGS SHALL change nothing.
REQ-007 SHALL, when RE is sampled high, drive RDATA with the register value from before that edge's writes, and assert RVALID, exactly one cycle later.
REQ-008 SHALL return 0 on RDATA for out-of-range reads; RDATA SHALL hold its last value while RVALID is low.
REQ-009 SHALL, for simultaneous RE and WE to the same address, return the old value (read-before-write).
REQ-010 SHALL handle START as follows:
- A write with BE[0]=1 and WDATA[0]=1 while BUSY=0 sets bit 0 and pulses START_PULSE in the following cycle.
- The same write while BUSY=1 is ignored (no pulse).
- Writing 0 does not clear the bit.
- Other START bits read 0.
REQ-011 SHALL, on HW_DONE, in the same edge:
- load regs 8-11 from HW_DEC (reg8 = HW_DEC[DATA_W-1:0], ascending);
- clear START bit 0;
- set DONE bit 0.
REQ-012 SHALL give HW_DONE priority over a same-cycle software write to regs 8-11, START or DONE.
REQ-013 SHALL make DONE bit 0 write-1-to-clear (BE[0]=1, WDATA[0]=1); other DONE bits read 0 and ignore writes.
REQ-014 SHALL, if HW_DONE arrives while BUSY=0, still load regs 8-11 and set DONE, with no START_PULSE.
REQ-015 SHALL update AES_KEY and AES_MSG_EN combinationally from register state.

Reset
REQ-016 SHALL, while Reset=1, asynchronously clear every register, RDATA, RVALID, START_PULSE and IRQ to 0.
REQ-017 SHALL discard any in-flight read when Reset is asserted mid-transaction; no RVALID follows it.
REQ-018 SHALL, on Reset during BUSY=1, drop BUSY to 0 immediately; a later HW_DONE is handled per REQ-014.

Configuration
REQ-019 SHALL compile the interrupt logic only when macro AES_REG_IRQ_EN is defined:
- With AES_REG_IRQ_EN defined: CTRL bit 0 is interrupt enable, and IRQ is a registered copy of (DONE bit 0 AND CTRL bit 0), one cycle behind.
- Without AES_REG_IRQ_EN: IRQ is tied to 0 and CTRL is a plain register.

Verification
REQ-020 SHALL pass these directed scenarios:
- Write 0xDEADBEEF with BE=4'b0101 to reg2 (held 0) -> read gives 0x00AD00EF, RVALID one cycle after RE; AES_KEY[95:64] = 0x00AD00EF.
- Write START=1 -> START_PULSE high for exactly 1 cycle and BUSY=1; second START write -> no pulse; HW_DONE with HW_DEC=128'h0123..CDEF -> reg8=0x89ABCDEF, BUSY=0, DONE=1.
- HW_DONE and software write 0x5 to reg9 in the same cycle -> reg9 holds the HW_DEC slice; DONE W1C in the same cycle as HW_DONE -> DONE stays 1.
- Read ADDR=NUM_REGS (with NUM_REGS=32, ADDR_W=6) -> RDATA=0, RVALID=1; same-cycle RE+WE to reg0 -> old value returned.
- With AES_REG_IRQ_EN: CTRL=1, then HW_DONE -> IRQ=1 one cycle after DONE sets; W1C DONE -> IRQ=0 next cycle. Without the macro -> IRQ always 0.
- Assert Reset mid-read and while BUSY=1 -> RVALID never pulses, all outputs 0, BUSY=0.
